// File: rtl/mem_responder.sv
// mem_responder: word-addressed memory target for the core's request port.
// It accepts one request at a time, waits WAIT_STATES cycles, then presents
// a registered response that is held until the requester takes it.
// Optional feature: define MEM_RESPONDER_ALIGN_CHECK_EN to turn misaligned
// byte addresses (addr[1:0] != 0) into error responses. When it is not
// defined, the low address bits are ignored.
module mem_responder #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic                  req_we_i,
  input  logic [3:0]            req_wstrb_i,
  input  logic [31:0]           req_wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [31:0]           rsp_rdata_o,
  output logic                  rsp_err_o
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_WIDTH:0] ADDR_LIMIT = (ADDR_WIDTH + 1)'(DEPTH_WORDS * 4);
  localparam logic [3:0] CNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  we_q, we_d;
  logic [3:0]            wstrb_q, wstrb_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  ready_q, ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic [ADDR_WIDTH-1:0] cur_addr_s;
  logic                  cur_we_s;
  logic [3:0]            cur_wstrb_s;
  logic [31:0]           cur_wdata_s;
  logic [IDX_W-1:0]      cur_idx_s;
  logic                  range_err_s;
  logic                  align_err_s;
  logic                  fault_s;
  logic [31:0]           resp_rdata_s;
  logic                  enter_resp_s;
  logic                  mem_we_s;

  // Storage array; contents deliberately survive reset.
  logic [31:0] mem_q [DEPTH_WORDS];

  // Merge new write data into an old word, byte lane by byte lane.
  function automatic logic [31:0] merge_lanes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_w;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) begin
        res[8*i +: 8] = new_w[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_w[8*i +: 8];
      end
    end
    return res;
  endfunction

  // Select the request being served: live inputs in IDLE (zero-wait path), captured copy otherwise.
  always_comb begin
    cur_addr_s  = addr_q;
    cur_we_s    = we_q;
    cur_wstrb_s = wstrb_q;
    cur_wdata_s = wdata_q;
    if (state_q == ST_IDLE) begin
      cur_addr_s  = req_addr_i;
      cur_we_s    = req_we_i;
      cur_wstrb_s = req_wstrb_i;
      cur_wdata_s = req_wdata_i;
    end else begin
      cur_addr_s  = addr_q;
      cur_we_s    = we_q;
      cur_wstrb_s = wstrb_q;
      cur_wdata_s = wdata_q;
    end
  end

  assign cur_idx_s   = cur_addr_s[IDX_W+1:2];
  assign range_err_s = ({1'b0, cur_addr_s} >= ADDR_LIMIT);
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
  assign align_err_s = (cur_addr_s[1:0] != 2'b00);
`else
  assign align_err_s = 1'b0;
`endif
  assign fault_s      = range_err_s | align_err_s;
  assign resp_rdata_s = (fault_s || cur_we_s) ? 32'd0 : mem_q[cur_idx_s];
  assign mem_we_s     = enter_resp_s & cur_we_s & ~fault_s;

  // Next-state, wait counter, request capture and response-register logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    we_d         = we_q;
    wstrb_d      = wstrb_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    enter_resp_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid_i && ready_q) begin
          addr_d  = req_addr_i;
          we_d    = req_we_i;
          wstrb_d = req_wstrb_i;
          wdata_d = req_wdata_i;
          cnt_d   = CNT_LOAD;
          if (WAIT_STATES > 0) begin
            state_d = ST_WAIT;
          end else begin
            state_d      = ST_RESP;
            enter_resp_s = 1'b1;
            rdata_d      = resp_rdata_s;
            err_d        = fault_s;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d      = ST_RESP;
          enter_resp_s = 1'b1;
          rdata_d      = resp_rdata_s;
          err_d        = fault_s;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        // Retire only once the response is actually visible to the requester.
        if (rsp_valid_q && rsp_ready_i) begin
          state_d = ST_IDLE;
          rdata_d = 32'd0;
          err_d   = 1'b0;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    ready_d     = (state_d == ST_IDLE);
    // Response valid trails the RESP entry by one edge, giving 1+WAIT_STATES latency.
    rsp_valid_d = (state_q == ST_RESP) && (state_d == ST_RESP);
  end

  // Control and response registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wstrb_q     <= 4'd0;
      wdata_q     <= 32'd0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= 32'd0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wstrb_q     <= wstrb_d;
      wdata_q     <= wdata_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  // Commit writes on the edge that enters RESP; an in-flight write lost to reset never commits.
  always_ff @(posedge clk_i) begin
    if (mem_we_s) begin
      mem_q[cur_idx_s] <= merge_lanes(mem_q[cur_idx_s], cur_wdata_s, cur_wstrb_s);
    end
  end

  assign req_ready_o = ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;

endmodule
